pq_id_frontend: RTL and testbench
=================================

// Module: pq_id_frontend
// PURPOSE
//  Front-end stage for the hardware priority queue. Accepts push requests over a
//  valid/ready handshake, allocates a unique cell ID from a free pool, and registers
//  the {data,id} cell toward the queue. On the pop side it forwards the queue head
//  downstream and returns the popped ID to the pool. It also tracks occupancy so
//  the queue is never overfilled.
// PARAMETERS
//  QUEUE_DEPTH  8                 max cells resident in queue (pq_pkg)
//  DATA_WIDTH   8                 payload width (pq_pkg)
//  ID_WIDTH     $clog2(DEPTH)+1   cell ID width; pool size ID_POOL=2**ID_WIDTH
// PORTS
//  clk_i          in   1           clock; single clock domain
//  rst_i          in   1           synchronous reset, active-high
//  push_valid_i   in   1           push request
//  push_ready_o   out  1           push accepted when valid&ready
//  push_data_i    in   DATA_WIDTH  push payload
//  push_id_o      out  ID_WIDTH    ID assigned to the accepted push (valid on handshake)
//  pq_push_o      out  1           one-cycle push strobe to queue
//  pq_cell_o      out  cell_t      cell to queue, valid with pq_push_o
//  pq_empty_i     in   1           queue holds no cells
//  pq_head_i      in   cell_t      current queue head (valid when !pq_empty_i)
//  pq_pop_o       out  1           pop strobe to queue
//  pop_valid_o    out  1           head available downstream
//  pop_ready_i    in   1           downstream consumes head
//  pop_data_o     out  DATA_WIDTH  head payload
//  pop_id_o       out  ID_WIDTH    head ID
//  occupancy_o    out  CNT_WIDTH+1 accepted-but-not-popped cells
//  err_o          out  1           sticky: popped ID was not allocated
// BEHAVIOUR
//  Reset: all IDs free, occupancy_o=0, pq_push_o=0, pq_cell_o=0, err_o=0;
//   push_ready_o is forced 0 while rst_i=1.
//  Ready: push_ready_o = !rst_i & (occupancy_o < QUEUE_DEPTH). It depends only on
//   registered state; a same-cycle pop does not open space.
//  Allocation: push_id_o = lowest-index free ID, driven combinationally. On accept,
//   that ID is marked busy at the next edge. ID_POOL > QUEUE_DEPTH, so a free ID
//   always exists whenever ready=1.
//  Push latency: accept in cycle N -> pq_push_o=1 and pq_cell_o={data,id} in cycle
//   N+1 (registered). Back-to-back accepts give back-to-back strobes.
//  Pop: pop_valid_o = !pq_empty_i. pop_data_o and pop_id_o come from pq_head_i.
//   pq_pop_o = pop_valid_o & pop_ready_i (combinational). In the same cycle the
//   head ID is freed (next edge) and occupancy is decremented.
//  Simultaneous push+pop: occupancy unchanged. An ID freed in cycle N is not
//   allocatable until N+1, so no same-cycle reuse.
//  Occupancy: counts accepted pushes, including the one in the output register.
//   +1 on accept, -1 on pop, saturates at 0/QUEUE_DEPTH.
//  Error: a pop whose pq_head_i.id is not marked busy -> err_o=1 (sticky until
//   reset). Occupancy still decrements (nonzero); bitmap unchanged for that ID.
//  Mid-operation reset: a pending pq_push_o is dropped; the queue must be reset in
//   the same cycle.
// STRUCTURE
//  pq_pkg additions: ID_POOL, typedef logic [ID_WIDTH-1:0] id_t,
//   typedef logic [CNT_WIDTH:0] occ_t.
//  Sub-module pq_free_list: ID_POOL-bit busy bitmap, lowest-free priority encoder,
//   alloc/release ports, release-of-free flag. The top holds the push register,
//   occupancy counter and pop glue.
// TESTING
//  1 reset -> push_ready_o=1, occupancy_o=0, err_o=0, pq_push_o=0.
//  2 push 0x11,0x22,0x33 back-to-back -> push_id_o=0,1,2; pq_cell_o={0x11,0},
//    {0x22,1},{0x33,2} in cycles N+1..N+3.
//  3 8 pushes, no pops -> push_ready_o=0 after 8th accept, occupancy_o=8;
//    a held 9th push is not accepted.
//  4 occ=3 (IDs 0-2), head id 0: pop and push same cycle -> new ID=3, occ stays 3;
//    next push gets ID 0.
//  5 pq_head_i.id=5 unallocated, pop -> err_o=1 next cycle and stays 1 afterward.
//  6 rst_i asserted during cycle N+1 of a push -> pq_push_o=0, all IDs free,
//    next push gets ID 0.

Source files
------------

// File: rtl/pq_pkg.sv
`default_nettype none
// ============================================================================
// Module : pq_pkg
// Desc   : Shared sizes and cell types for the priority-queue ID front end.
// Rev    : 1.0
// ============================================================================
package pq_pkg;
    localparam int QUEUE_DEPTH = 8;
    localparam int DATA_WIDTH  = 8;
    localparam int CNT_WIDTH   = $clog2(QUEUE_DEPTH);
    localparam int ID_WIDTH    = CNT_WIDTH + 1;
    localparam int ID_POOL     = 2 ** ID_WIDTH;

    typedef logic [ID_WIDTH-1:0]   id_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [CNT_WIDTH:0]    occ_t;

    typedef struct packed {
        data_t data;
        id_t   id;
    } cell_t;

    localparam occ_t c_occ_max = occ_t'(QUEUE_DEPTH);
endpackage
`default_nettype wire

// File: rtl/pq_id_frontend_if.sv
`default_nettype none
// ============================================================================
// Module : pq_id_frontend_if
// Desc   : Push, queue and pop signal bundle for the ID front end.
// Rev    : 1.0
// ============================================================================
interface pq_id_frontend_if;
    import pq_pkg::*;

    logic  push_valid_i;
    logic  push_ready_o;
    data_t push_data_i;
    id_t   push_id_o;
    logic  pq_push_o;
    cell_t pq_cell_o;
    logic  pq_empty_i;
    cell_t pq_head_i;
    logic  pq_pop_o;
    logic  pop_valid_o;
    logic  pop_ready_i;
    data_t pop_data_o;
    id_t   pop_id_o;
    occ_t  occupancy_o;
    logic  err_o;

    // Front-end side
    modport slave (
        input  push_valid_i, push_data_i, pq_empty_i, pq_head_i, pop_ready_i,
        output push_ready_o, push_id_o, pq_push_o, pq_cell_o, pq_pop_o,
               pop_valid_o, pop_data_o, pop_id_o, occupancy_o, err_o
    );

    // Producer / queue / consumer side
    modport master (
        output push_valid_i, push_data_i, pq_empty_i, pq_head_i, pop_ready_i,
        input  push_ready_o, push_id_o, pq_push_o, pq_cell_o, pq_pop_o,
               pop_valid_o, pop_data_o, pop_id_o, occupancy_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/pq_free_list.sv
`default_nettype none
// ============================================================================
// Module : pq_free_list
// Desc   : Busy bitmap of cell IDs with lowest-free-index allocation.
// Rev    : 1.0
// ============================================================================
module pq_free_list
    import pq_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_alloc,
    output id_t       o_free_id,
    input  wire logic i_release,
    input  id_t       i_release_id,
    output logic      o_release_err
);
    logic [ID_POOL-1:0] r_busy;
    id_t                w_free_id;

    // Scan high to low so the last hit is the lowest free index
    always_comb begin
        w_free_id = '0;
        for (int i = ID_POOL - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_id = id_t'(i);
        end
    end

    assign o_free_id     = w_free_id;
    assign o_release_err = i_release && !r_busy[i_release_id];

    // A released ID is only visible as free after this edge, never same-cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (i_alloc) r_busy[w_free_id] <= 1'b1;
            if (i_release && r_busy[i_release_id]) r_busy[i_release_id] <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/pq_id_frontend.sv
`default_nettype none
// ============================================================================
// Module : pq_id_frontend
// Desc   : Push ID allocation, registered queue push, pop glue and occupancy.
// Rev    : 1.0
// ============================================================================
module pq_id_frontend
    import pq_pkg::*;
(
    input wire logic          clk_i,
    input wire logic          rst_i,
    pq_id_frontend_if.slave   bus
);
    logic  w_push_ready;
    logic  w_accept;
    logic  w_pop;
    logic  w_release_err;
    id_t   w_free_id;

    logic  r_push;
    cell_t r_cell;
    occ_t  r_occ;
    logic  r_err;

    // Space is judged on registered occupancy only; a same-cycle pop does not help
    assign w_push_ready = !rst_i && (r_occ < c_occ_max);
    assign w_accept     = bus.push_valid_i && w_push_ready;
    assign w_pop        = !bus.pq_empty_i && bus.pop_ready_i;

    pq_free_list u_free_list (
        .clk           (clk_i),
        .rst           (rst_i),
        .i_alloc       (w_accept),
        .o_free_id     (w_free_id),
        .i_release     (w_pop),
        .i_release_id  (bus.pq_head_i.id),
        .o_release_err (w_release_err)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_push <= 1'b0;
            r_cell <= '0;
            r_occ  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_push <= w_accept;
            if (w_accept) r_cell <= '{data: bus.push_data_i, id: w_free_id};
            if (w_accept && !w_pop) begin
                if (r_occ != c_occ_max) r_occ <= r_occ + occ_t'(1);
            end else if (w_pop && !w_accept) begin
                if (r_occ != '0) r_occ <= r_occ - occ_t'(1);
            end
            if (w_pop && w_release_err) r_err <= 1'b1;
        end
    end

    assign bus.push_ready_o = w_push_ready;
    assign bus.push_id_o    = w_free_id;
    assign bus.pq_push_o    = r_push;
    assign bus.pq_cell_o    = r_cell;
    assign bus.pq_pop_o     = w_pop;
    assign bus.pop_valid_o  = !bus.pq_empty_i;
    assign bus.pop_data_o   = bus.pq_head_i.data;
    assign bus.pop_id_o     = bus.pq_head_i.id;
    assign bus.occupancy_o  = r_occ;
    assign bus.err_o        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_pq_id_frontend.sv
`default_nettype none
// ============================================================================
// Module : tb_pq_id_frontend
// Desc   : Directed self-checking bench for pq_id_frontend.
// Rev    : 1.0
// ============================================================================
module tb_pq_id_frontend;
    import pq_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    pq_id_frontend_if bus ();

    pq_id_frontend dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.push_valid_i = 1'b0;
        bus.pq_empty_i   = 1'b1;
        bus.pop_ready_i  = 1'b0;
        tick;
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] d, input logic [3:0] exp_id, input string tag);
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = d;
        #1;
        check({tag, "_id"}, 32'(bus.push_id_o), 32'(exp_id));
        tick;
        check({tag, "_cell"}, 32'({bus.pq_push_o, bus.pq_cell_o}), 32'({1'b1, d, exp_id}));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.push_valid_i = 1'b0;
        bus.push_data_i  = '0;
        bus.pq_empty_i   = 1'b1;
        bus.pq_head_i    = '0;
        bus.pop_ready_i  = 1'b0;

        // 1: reset state
        tick;
        #1;
        check("rst_ready", 32'(bus.push_ready_o), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        check("ready", 32'(bus.push_ready_o), 32'd1);
        check("occ0", 32'(bus.occupancy_o), 32'd0);
        check("err0", 32'(bus.err_o), 32'd0);
        check("push0", 32'(bus.pq_push_o), 32'd0);
        check("cell0", 32'(bus.pq_cell_o), 32'd0);

        // 2: back-to-back pushes
        push_one(8'h11, 4'd0, "b2b0");
        push_one(8'h22, 4'd1, "b2b1");
        push_one(8'h33, 4'd2, "b2b2");
        bus.push_valid_i = 1'b0;
        tick;
        check("b2b_idle", 32'(bus.pq_push_o), 32'd0);
        check("b2b_occ", 32'(bus.occupancy_o), 32'd3);

        // Drain via pops of heads 0,1,2
        for (int i = 0; i < 3; i++) begin
            bus.pq_empty_i  = 1'b0;
            bus.pop_ready_i = 1'b1;
            bus.pq_head_i   = '{data: 8'(8'h11 * (i + 1)), id: 4'(i)};
            #1;
            check("pop_strobe", 32'({bus.pop_valid_o, bus.pq_pop_o}), 32'h3);
            check("pop_head", 32'({bus.pop_data_o, bus.pop_id_o}), 32'({8'(8'h11 * (i + 1)), 4'(i)}));
            tick;
        end
        bus.pq_empty_i  = 1'b1;
        bus.pop_ready_i = 1'b0;
        #1;
        check("drain_occ", 32'(bus.occupancy_o), 32'd0);
        check("drain_pop", 32'(bus.pq_pop_o), 32'd0);
        check("drain_err", 32'(bus.err_o), 32'd0);

        // 3: fill to depth
        for (int i = 0; i < 8; i++) push_one(8'(8'hA0 + i), 4'(i), "fill");
        check("full_occ", 32'(bus.occupancy_o), 32'd8);
        check("full_ready", 32'(bus.push_ready_o), 32'd0);
        tick;
        check("full_nopush", 32'(bus.pq_push_o), 32'd0);
        check("full_occ_hold", 32'(bus.occupancy_o), 32'd8);
        bus.push_valid_i = 1'b0;

        // 4: simultaneous push and pop, no same-cycle ID reuse
        do_reset;
        push_one(8'h11, 4'd0, "s0");
        push_one(8'h22, 4'd1, "s1");
        push_one(8'h33, 4'd2, "s2");
        bus.pq_empty_i  = 1'b0;
        bus.pop_ready_i = 1'b1;
        bus.pq_head_i   = '{data: 8'h11, id: 4'd0};
        push_one(8'h44, 4'd3, "simul");
        check("simul_occ", 32'(bus.occupancy_o), 32'd3);
        bus.pq_empty_i  = 1'b1;
        bus.pop_ready_i = 1'b0;
        push_one(8'h55, 4'd0, "reuse");
        bus.push_valid_i = 1'b0;
        check("reuse_occ", 32'(bus.occupancy_o), 32'd4);

        // 5: pop of an unallocated ID sets sticky error
        bus.pq_empty_i  = 1'b0;
        bus.pop_ready_i = 1'b1;
        bus.pq_head_i   = '{data: 8'h99, id: 4'd5};
        #1;
        check("err_before", 32'(bus.err_o), 32'd0);
        tick;
        bus.pq_empty_i  = 1'b1;
        bus.pop_ready_i = 1'b0;
        check("err_set", 32'(bus.err_o), 32'd1);
        check("err_occ", 32'(bus.occupancy_o), 32'd3);
        tick;
        tick;
        check("err_sticky", 32'(bus.err_o), 32'd1);
        #1;
        check("err_next_id", 32'(bus.push_id_o), 32'd4);

        // 6: reset while a push strobe is pending
        push_one(8'h66, 4'd4, "pend");
        rst = 1'b1;
        bus.push_valid_i = 1'b0;
        #1;
        check("rst_ready_mid", 32'(bus.push_ready_o), 32'd0);
        tick;
        rst = 1'b0;
        check("rst_drop", 32'(bus.pq_push_o), 32'd0);
        check("rst_occ", 32'(bus.occupancy_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        push_one(8'h77, 4'd0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
